// File: rtl/axil_initiator_pkg.sv
// Shared AXI4-Lite types: response codes used by slaves too, and the initiator FSM states.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axil_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RESP
    } axil_init_state_t;

endpackage

// File: rtl/axil_initiator_if.sv
// AXI4-Lite bus bundle, 32-bit data; M is the initiator view, S the slave view.
interface AxiLite #(
    parameter int ADDR_W = 32
);
    logic              awValid;
    logic              awReady;
    logic [ADDR_W-1:0] awAddr;
    logic [2:0]        awProt;
    logic              wValid;
    logic              wReady;
    logic [31:0]       wData;
    logic [3:0]        wStrb;
    logic              bValid;
    logic              bReady;
    logic [1:0]        bResp;
    logic              arValid;
    logic              arReady;
    logic [ADDR_W-1:0] arAddr;
    logic [2:0]        arProt;
    logic              rValid;
    logic              rReady;
    logic [31:0]       rData;
    logic [1:0]        rResp;

    modport M (
        output awValid, awAddr, awProt, wValid, wData, wStrb, bReady,
               arValid, arAddr, arProt, rReady,
        input  awReady, wReady, bValid, bResp, arReady, rValid, rData, rResp
    );

    modport S (
        input  awValid, awAddr, awProt, wValid, wData, wStrb, bReady,
               arValid, arAddr, arProt, rReady,
        output awReady, wReady, bValid, bResp, arReady, rValid, rData, rResp
    );
endinterface

// File: rtl/axil_initiator.sv
// Single-outstanding AXI4-Lite initiator: one command in, one bus transaction, one response out,
// with a sticky saturating timeout flag for spotting hung slaves.
module axil_initiator
    import axil_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    AxiLite.M                 bus,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdWrite,
    input  logic [ADDR_W-1:0] cmdAddr,
    input  logic [31:0]       cmdData,
    input  logic [3:0]        cmdStrb,
    output logic              rspValid,
    input  logic              rspReady,
    output logic              rspWrite,
    output logic [31:0]       rspData,
    output logic [1:0]        rspResp,
    output logic              busy,
    output logic              timeout
);
    localparam int BusAddrW = $bits(bus.awAddr);
    localparam int CntW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    if (ADDR_W > BusAddrW) begin : g_addrCheck
        $error("axil_initiator: ADDR_W exceeds the bus address width");
    end

    axil_init_state_t    stateQ, stateD;
    logic                awValidQ, awValidD, wValidQ, wValidD, arValidQ, arValidD;
    logic                bReadyQ, bReadyD, rReadyQ, rReadyD;
    logic                rspValidQ, rspValidD, rspWriteQ, rspWriteD;
    logic [31:0]         rspDataQ, rspDataD;
    axil_resp_t          rspRespQ, rspRespD;
    logic [BusAddrW-1:0] addrQ, addrD;
    logic [31:0]         dataQ, dataD;
    logic [3:0]          strbQ, strbD;
    logic                timeoutQ, timeoutD;
    logic [CntW-1:0]     cntQ, cntD;
    logic                awDone, wDone;

    always_ff @(posedge aclk) begin
        if (areset) begin
            stateQ    <= IDLE;
            awValidQ  <= 1'b0;
            wValidQ   <= 1'b0;
            arValidQ  <= 1'b0;
            bReadyQ   <= 1'b0;
            rReadyQ   <= 1'b0;
            rspValidQ <= 1'b0;
            rspWriteQ <= 1'b0;
            rspDataQ  <= '0;
            rspRespQ  <= OKAY;
            addrQ     <= '0;
            dataQ     <= '0;
            strbQ     <= '0;
            timeoutQ  <= 1'b0;
            cntQ      <= '0;
        end else begin
            stateQ    <= stateD;
            awValidQ  <= awValidD;
            wValidQ   <= wValidD;
            arValidQ  <= arValidD;
            bReadyQ   <= bReadyD;
            rReadyQ   <= rReadyD;
            rspValidQ <= rspValidD;
            rspWriteQ <= rspWriteD;
            rspDataQ  <= rspDataD;
            rspRespQ  <= rspRespD;
            addrQ     <= addrD;
            dataQ     <= dataD;
            strbQ     <= strbD;
            timeoutQ  <= timeoutD;
            cntQ      <= cntD;
        end
    end

    // A channel whose valid already dropped has handshaken earlier, so it counts as done.
    assign awDone = !awValidQ || bus.awReady;
    assign wDone  = !wValidQ || bus.wReady;

    always_comb begin
        stateD    = stateQ;
        awValidD  = awValidQ;
        wValidD   = wValidQ;
        arValidD  = arValidQ;
        bReadyD   = bReadyQ;
        rReadyD   = rReadyQ;
        rspValidD = rspValidQ;
        rspWriteD = rspWriteQ;
        rspDataD  = rspDataQ;
        rspRespD  = rspRespQ;
        addrD     = addrQ;
        dataD     = dataQ;
        strbD     = strbQ;
        timeoutD  = timeoutQ;
        cntD      = cntQ;

        case (stateQ)
            IDLE: begin
                if (cmdValid) begin
                    addrD    = BusAddrW'(cmdAddr & ~ADDR_W'(3));
                    dataD    = cmdData;
                    strbD    = cmdStrb;
                    cntD     = '0;
                    timeoutD = 1'b0;
                    if (cmdWrite) begin
                        stateD   = WADDR;
                        awValidD = 1'b1;
                        wValidD  = 1'b1;
                    end else begin
                        stateD   = RADDR;
                        arValidD = 1'b1;
                    end
                end
            end
            WADDR: begin
                if (awValidQ && bus.awReady) awValidD = 1'b0;
                if (wValidQ && bus.wReady)   wValidD  = 1'b0;
                if (awDone && wDone) begin
                    stateD  = WRESP;
                    bReadyD = 1'b1;
                end
            end
            WRESP: begin
                if (bus.bValid) begin
                    stateD    = RESP;
                    bReadyD   = 1'b0;
                    rspValidD = 1'b1;
                    rspWriteD = 1'b1;
                    rspDataD  = '0;
                    rspRespD  = axil_resp_t'(bus.bResp);
                end
            end
            RADDR: begin
                if (bus.arReady) begin
                    stateD   = RDATA;
                    arValidD = 1'b0;
                    rReadyD  = 1'b1;
                end
            end
            RDATA: begin
                if (bus.rValid) begin
                    stateD    = RESP;
                    rReadyD   = 1'b0;
                    rspValidD = 1'b1;
                    rspWriteD = 1'b0;
                    rspDataD  = bus.rData;
                    rspRespD  = axil_resp_t'(bus.rResp);
                end
            end
            RESP: begin
                if (rspReady) begin
                    stateD    = IDLE;
                    rspValidD = 1'b0;
                end
            end
            default: stateD = IDLE;
        endcase

        // Waiting on the bus only; the transaction is never aborted, the flag just latches.
        if (TIMEOUT != 0 && stateQ inside {WADDR, WRESP, RADDR, RDATA} && cntQ != CntW'(TIMEOUT)) begin
            cntD = cntQ + CntW'(1);
            if (cntD == CntW'(TIMEOUT)) timeoutD = 1'b1;
        end
    end

    assign cmdReady = (stateQ == IDLE) && !areset;
    assign busy     = (stateQ != IDLE);
    assign rspValid = rspValidQ;
    assign rspWrite = rspWriteQ;
    assign rspData  = rspDataQ;
    assign rspResp  = rspRespQ;
    assign timeout  = timeoutQ;

    assign bus.awValid = awValidQ;
    assign bus.awAddr  = addrQ;
    assign bus.awProt  = 3'b000;
    assign bus.wValid  = wValidQ;
    assign bus.wData   = dataQ;
    assign bus.wStrb   = strbQ;
    assign bus.bReady  = bReadyQ;
    assign bus.arValid = arValidQ;
    assign bus.arAddr  = addrQ;
    assign bus.arProt  = 3'b000;
    assign bus.rReady  = rReadyQ;

    awHold: assert property (@(posedge aclk) disable iff (areset) bus.awValid && !bus.awReady |=> bus.awValid);
    wHold:  assert property (@(posedge aclk) disable iff (areset) bus.wValid && !bus.wReady |=> bus.wValid);
    arHold: assert property (@(posedge aclk) disable iff (areset) bus.arValid && !bus.arReady |=> bus.arValid);

endmodule

// File: doc/axil_initiator.md
# axil_initiator

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command stream into AXI-Lite read or write transactions and returns one response per command. Sits between internal control logic (sequencers, boot loaders, debug bridges) and any AXI-Lite CSR slave in the design. Adds a sticky per-transaction timeout flag for hung-slave diagnosis.

## Interface
- ADDR_W, 32: command address width; must be ≤ bus.ADDR_W (elaboration `$error` otherwise).
- TIMEOUT, 1024: cycles before `timeout` asserts; 0 disables the counter.

- aclk  in  1  clock; the bus interface must run on the same clock.
- areset  in  1  synchronous, active-high reset.
- bus  AxiLite.M  —  initiator modport, 32-bit data, 4-bit strobe.
- cmdValid  in  1  command present.
- cmdReady  out  1  command accepted when both cmdValid and cmdReady are high.
- cmdWrite  in  1  1 = write, 0 = read.
- cmdAddr  in  ADDR_W  byte address; bits [1:0] forced to 0 on the bus.
- cmdData  in  32  write data; ignored for reads.
- cmdStrb  in  4  write strobes; ignored for reads.
- rspValid  out  1  response present.
- rspReady  in  1  response consumed.
- rspWrite  out  1  copy of cmdWrite for this response.
- rspData  out  32  read data; 0 for writes.
- rspResp  out  2  bResp or rResp, as returned by the slave.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky; cleared on the next command accept.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RESP. All outputs are registered except cmdReady and busy, which decode directly from state.
- IDLE
  - cmdReady = 1.
  - On accept, latch addr/data/strb/write and go to WADDR or RADDR.
- WADDR
  - awValid and wValid both assert on entry.
  - Each drops independently on its own handshake.
  - Both may complete in the same cycle or in either order.
  - The state exits to WRESP once both handshakes are done.
- WRESP
  - bReady = 1.
  - On B handshake, capture bResp, set rspData = 0, go to RESP.
- RADDR
  - arValid = 1 until handshake, then go to RDATA.
- RDATA
  - rReady = 1.
  - On R handshake, capture rData/rResp, go to RESP.
- RESP
  - rspValid = 1 until rspReady, then go to IDLE.
- awProt/arProt = 3'b000. Bus address is zero-extended from ADDR_W, with [1:0] = 0.
- Timeout counter
  - Clears on accept and increments each cycle in WADDR/WRESP/RADDR/RDATA.
  - Saturates at TIMEOUT; reaching TIMEOUT sets `timeout`.
  - The transaction is never aborted; the FSM keeps waiting.
- Reset
  - All bus valids/readies low; rspValid, timeout and the counter cleared; state IDLE.
  - rspData/rspResp/rspWrite are 0.
  - cmdReady is 0 while areset is high and 1 in the first cycle after.
- Reset mid-transaction: return to IDLE immediately, emit no response. The slave must be reset in the same domain.

## Timing
- Write, zero-wait slave: accept at cycle N; aw/w handshake at N+1; B at N+2; rspValid at N+3. Next cmdReady comes the cycle after the rsp handshake.
- Read, zero-wait slave: accept N; AR at N+1; R at N+2; rspValid at N+3.
- Minimum command-to-command interval: 4 cycles with rspReady held high.
- Command inputs are sampled only on accept; they may change freely afterwards.
- Bus valids never drop before their handshake (AXI rule); covered by assertion.
- Only one transaction is in flight; there is no overlap of read and write.
- With TIMEOUT = T, `timeout` rises exactly T cycles after the first cycle in WADDR/RADDR if no completion occurs.

## Structure
- axil_pkg holds:
  - `axil_resp_t` enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), shared with slave blocks.
  - `axil_init_state_t` FSM enum.
- Single module. The timeout counter is inline; no sub-module is warranted.

## Test plan
- Write 0x0000_0010, data 0xDEADBEEF, strb 0xF, zero-wait slave → aw/w at N+1, rsp at N+3 with rspResp=0, rspData=0. Slave register reads back 0xDEADBEEF.
- Read 0x0000_0014, slave returns 0x1234_5678 after 5 wait cycles on R → rspData=0x12345678, rspResp=0, busy for 8 cycles.
- Write where wReady comes 3 cycles before awReady, then the reverse → wValid and awValid each drop on their own handshake, exactly one B accepted, single response.
- TIMEOUT=16, slave never asserts bValid → `timeout` rises 16 cycles after WADDR entry and stays high. A late B completes normally, and the next accept clears `timeout`.
- Slave returns SLVERR on read; rspReady held low 10 cycles → rspValid stable with rspResp=2 and cmdReady=0 throughout. The next command is accepted only after the rsp handshake.
- areset asserted during WRESP → all valids/readies 0 and no rspValid. cmdReady=1 in the first cycle after reset deasserts.
